offchip_link_rx: RTL and testbench
==================================

# offchip_link_rx

Parametrised receive side of the off-chip link. It accepts NUM_CH narrow physical channels that share one valid strobe. It reassembles BEATS consecutive beats into one core word and buffers up to DEPTH words in a show-ahead FIFO for the core. Credits go back to the transmitter as a toggle-encoded token, one toggle per TOKEN_DECIM words the core consumes. It replaces the fixed two-instance downstream pair with its external memories, and adds overflow detection and occupancy reporting.

## Interface
- NUM_CH, default 2: number of physical channels; must be ≥1.
- CH_W, default 8: width of each channel in bits.
- BEATS, default 4: beats per core word; must be ≥1.
- DEPTH, default 8: FIFO depth in core words; must be a power of two, ≥2.
- TOKEN_DECIM, default 2: number of dequeued words per token toggle; must be ≥1 and must divide DEPTH.
- Derived: WORD_W = NUM_CH*CH_W*BEATS; OCC_W = $clog2(DEPTH+1).

Ports:
- clk  in  1  single clock for the whole block.
- rst  in  1  synchronous, active-high reset.
- io_valid_in  in  1  beat strobe; all channels are valid together.
- io_data_in  in  NUM_CH*CH_W  channel c occupies bits [c*CH_W +: CH_W].
- io_token_out  out  1  credit token; each toggle returns TOKEN_DECIM credits.
- core_data_out  out  WORD_W  head-of-FIFO word.
- core_valid_out  out  1  FIFO is non-empty.
- core_ready  in  1  core accepts the head word.
- overflow  out  1  sticky error flag: a word was dropped because the FIFO was full.
- occupancy  out  OCC_W  number of words currently stored.

## Operation
- Beat assembler:
  - beat_cnt runs 0..BEATS-1.
  - On each io_valid_in cycle, channel c's byte lands in the assembly register at bit position c*BEATS*CH_W + beat_cnt*CH_W.
  - Each channel therefore owns a contiguous WORD_W/NUM_CH slice, with beat 0 least significant.
  - beat_cnt advances only on io_valid_in. It wraps to 0 after BEATS-1.
- Enqueue: occurs on the cycle that carries the last beat (io_valid_in && beat_cnt==BEATS-1). The word written is the previously captured beats plus the current beat, so the enqueue path bypasses the assembly register.
- Acceptance:
  - An enqueue is accepted if occupancy<DEPTH, or if a dequeue happens in the same cycle.
  - Otherwise the word is dropped and overflow is set. overflow stays set until rst.
  - The assembler continues with the next word in either case.
- Dequeue: occurs when core_valid_out && core_ready. Read pointer advances by 1.
- FIFO indexing:
  - Write and read pointers are log2(DEPTH) bits and wrap naturally.
  - occupancy is a separate counter: +1 on enqueue only, −1 on dequeue only, unchanged on both or neither.
- Token generator:
  - tok_cnt counts dequeues modulo TOKEN_DECIM.
  - When a dequeue occurs with tok_cnt==TOKEN_DECIM-1, io_token_out toggles and tok_cnt returns to 0.
  - With TOKEN_DECIM=1, every dequeue toggles io_token_out.
- Reset (rst=1):
  - beat_cnt=0, assembly register=0, all FIFO storage=0, pointers=0.
  - occupancy=0, core_valid_out=0, core_data_out=0.
  - io_token_out=0, tok_cnt=0, overflow=0.
  - Reset asserted mid-word discards the partial word. Reset asserted mid-stream discards all buffered words.
  - Inputs are ignored on any cycle where rst=1.

## Timing
- Enqueue-to-output latency: last beat at edge t → core_valid_out=1 and core_data_out=word after edge t. There is no combinational path from io_* to core_*.
- core_data_out is driven combinationally from storage[rd_ptr]. It is stable while core_valid_out=1 and core_ready=0.
- Dequeue at edge t → next head word (if any) or core_valid_out=0 after edge t.
- Token toggle is registered and appears after the edge of the qualifying dequeue.
- Full with simultaneous last beat and dequeue: both happen, occupancy stays DEPTH, and overflow is not set.
- Empty with simultaneous last beat and core_ready=1: no dequeue, since core_valid_out=0. The word appears the next cycle.
- Back-to-back words with BEATS=1: one enqueue per io_valid_in cycle, sustained.

## Test plan
- Reassembly (defaults): io_data_in = 16'hB0A0, 16'hB1A1, 16'hB2A2, 16'hB3A3 on consecutive cycles → one cycle after the 4th beat, core_valid_out=1, core_data_out=64'hB3B2B1B0_A3A2A1A0, occupancy=1.
- Gapped beats: the same 4 beats with 2 idle cycles between each → identical word, valid only after the 4th beat, no early enqueue.
- Fill and overflow: core_ready=0, send 9 words → occupancy=8 after the 8th; the 9th is dropped and overflow=1. Drain 8 words and check values 1..8 in order; the 9th word never appears.
- Full plus simultaneous dequeue: FIFO at 8 words, core_ready=1 on the cycle of a 9th word's last beat → occupancy stays 8, overflow=0, and the 9th word is read out last.
- Tokens: TOKEN_DECIM=2, dequeue 5 words → io_token_out toggles 0→1 after the 2nd dequeue and 1→0 after the 4th, and holds 0 after the 5th.
- Mid-word reset: 2 beats sent, rst pulsed 1 cycle, then 4 fresh beats → exactly one word equal to the fresh beats. All outputs read 0 on the cycle after the rst edge.

Source files
------------

// File: rtl/offchip_link_rx.sv
// Off-chip link receiver: beat reassembly into core words, show-ahead FIFO,
// toggle-encoded credit return, sticky overflow and occupancy reporting.
module offchip_link_rx #(
    parameter int NUM_CH      = 2,
    parameter int CH_W        = 8,
    parameter int BEATS       = 4,
    parameter int DEPTH       = 8,
    parameter int TOKEN_DECIM = 2,
    localparam int WORD_W     = NUM_CH * CH_W * BEATS,
    localparam int OCC_W      = $clog2(DEPTH + 1)
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   io_valid_in,
    input  logic [NUM_CH*CH_W-1:0] io_data_in,
    output logic                   io_token_out,
    output logic [WORD_W-1:0]      core_data_out,
    output logic                   core_valid_out,
    input  logic                   core_ready,
    output logic                   overflow,
    output logic [OCC_W-1:0]       occupancy
);

    localparam int PTR_W = $clog2(DEPTH);
    localparam int BC_W  = (BEATS > 1) ? $clog2(BEATS) : 1;
    localparam int TC_W  = (TOKEN_DECIM > 1) ? $clog2(TOKEN_DECIM) : 1;

    logic [BC_W-1:0]   beat_cnt_q, beat_cnt_d;
    logic [WORD_W-1:0] asm_q, asm_d;
    logic [WORD_W-1:0] mem_q [DEPTH];
    logic [PTR_W-1:0]  wr_ptr_q, rd_ptr_q;
    logic [OCC_W-1:0]  occ_q, occ_d;
    logic [TC_W-1:0]   tok_cnt_q, tok_cnt_d;
    logic              token_q, token_d;
    logic              ovf_q, ovf_d;
    logic              last_beat, enq, enq_ok, deq, full;

    assign last_beat = io_valid_in && (beat_cnt_q == BC_W'(BEATS - 1));
    assign full      = (occ_q == OCC_W'(DEPTH));
    assign deq       = (occ_q != '0) && core_ready;
    assign enq       = last_beat;
    assign enq_ok    = enq && (!full || deq);

    // asm_d carries the current beat so the last beat enqueues without delay
    always_comb begin
        asm_d      = asm_q;
        beat_cnt_d = beat_cnt_q;
        if (io_valid_in) begin
            for (int c = 0; c < NUM_CH; c++) begin
                asm_d[c*BEATS*CH_W + int'(beat_cnt_q)*CH_W +: CH_W] =
                    io_data_in[c*CH_W +: CH_W];
            end
            beat_cnt_d = last_beat ? '0 : beat_cnt_q + BC_W'(1);
        end
    end

    always_comb begin
        occ_d     = occ_q;
        ovf_d     = ovf_q;
        tok_cnt_d = tok_cnt_q;
        token_d   = token_q;
        if (enq_ok && !deq) begin
            occ_d = occ_q + OCC_W'(1);
        end else if (deq && !enq_ok) begin
            occ_d = occ_q - OCC_W'(1);
        end
        if (enq && !enq_ok) begin
            ovf_d = 1'b1;
        end
        if (deq) begin
            if (tok_cnt_q == TC_W'(TOKEN_DECIM - 1)) begin
                tok_cnt_d = '0;
                token_d   = ~token_q;
            end else begin
                tok_cnt_d = tok_cnt_q + TC_W'(1);
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            beat_cnt_q <= '0;
            asm_q      <= '0;
            wr_ptr_q   <= '0;
            rd_ptr_q   <= '0;
            occ_q      <= '0;
            tok_cnt_q  <= '0;
            token_q    <= 1'b0;
            ovf_q      <= 1'b0;
            for (int i = 0; i < DEPTH; i++) begin
                mem_q[i] <= '0;
            end
        end else begin
            beat_cnt_q <= beat_cnt_d;
            asm_q      <= asm_d;
            occ_q      <= occ_d;
            tok_cnt_q  <= tok_cnt_d;
            token_q    <= token_d;
            ovf_q      <= ovf_d;
            if (enq_ok) begin
                mem_q[wr_ptr_q] <= asm_d;
                wr_ptr_q        <= wr_ptr_q + PTR_W'(1);
            end
            if (deq) begin
                rd_ptr_q <= rd_ptr_q + PTR_W'(1);
            end
        end
    end

    assign core_data_out  = mem_q[rd_ptr_q];
    assign core_valid_out = (occ_q != '0);
    assign occupancy      = occ_q;
    assign overflow       = ovf_q;
    assign io_token_out   = token_q;

endmodule

// File: tb/tb_offchip_link_rx.sv
// Directed bench for offchip_link_rx at default parameters.
module tb_offchip_link_rx;

    logic        clk = 1'b0;
    logic        rst;
    logic        io_valid_in;
    logic [15:0] io_data_in;
    logic        io_token_out;
    logic [63:0] core_data_out;
    logic        core_valid_out;
    logic        core_ready;
    logic        overflow;
    logic [3:0]  occupancy;

    int checks   = 0;
    int failures = 0;

    offchip_link_rx dut (
        .clk            (clk),
        .rst            (rst),
        .io_valid_in    (io_valid_in),
        .io_data_in     (io_data_in),
        .io_token_out   (io_token_out),
        .core_data_out  (core_data_out),
        .core_valid_out (core_valid_out),
        .core_ready     (core_ready),
        .overflow       (overflow),
        .occupancy      (occupancy)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [63:0] obs,
                       input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        rst = 1'b1;
        tick();
        rst = 1'b0;
    endtask

    task automatic beat(input logic [15:0] d, input logic rdy);
        io_valid_in = 1'b1;
        io_data_in  = d;
        core_ready  = rdy;
        tick();
        io_valid_in = 1'b0;
        core_ready  = 1'b0;
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) tick();
    endtask

    task automatic pop();
        core_ready = 1'b1;
        tick();
        core_ready = 1'b0;
    endtask

    // word k: four beats of channel0=k, channel1=0
    task automatic send_word(input int k, input logic rdy_last);
        for (int b = 0; b < 4; b++) beat(16'(k), (b == 3) ? rdy_last : 1'b0);
    endtask

    function automatic logic [63:0] exp_word(input int k);
        logic [7:0] v;
        v = 8'(k);
        return {32'h0, v, v, v, v};
    endfunction

    initial begin
        rst         = 1'b1;
        io_valid_in = 1'b0;
        io_data_in  = '0;
        core_ready  = 1'b0;
        tick();
        tick();
        rst = 1'b0;
        chk("rst_valid", 64'(core_valid_out), 64'd0);
        chk("rst_data", core_data_out, 64'd0);
        chk("rst_occ", 64'(occupancy), 64'd0);
        chk("rst_tok", 64'(io_token_out), 64'd0);
        chk("rst_ovf", 64'(overflow), 64'd0);

        // consecutive reassembly
        beat(16'hB0A0, 1'b0);
        beat(16'hB1A1, 1'b0);
        beat(16'hB2A2, 1'b0);
        chk("asm_early", 64'(core_valid_out), 64'd0);
        beat(16'hB3A3, 1'b0);
        chk("asm_valid", 64'(core_valid_out), 64'd1);
        chk("asm_data", core_data_out, 64'hB3B2B1B0_A3A2A1A0);
        chk("asm_occ", 64'(occupancy), 64'd1);
        pop();
        chk("asm_popped", 64'(core_valid_out), 64'd0);

        // gapped beats
        do_reset();
        beat(16'hB0A0, 1'b0); idle(2);
        beat(16'hB1A1, 1'b0); idle(2);
        beat(16'hB2A2, 1'b0); idle(2);
        chk("gap_early", 64'(occupancy), 64'd0);
        beat(16'hB3A3, 1'b0);
        chk("gap_valid", 64'(core_valid_out), 64'd1);
        chk("gap_data", core_data_out, 64'hB3B2B1B0_A3A2A1A0);

        // fill and overflow
        do_reset();
        for (int k = 1; k <= 8; k++) send_word(k, 1'b0);
        chk("fill_occ", 64'(occupancy), 64'd8);
        chk("fill_ovf", 64'(overflow), 64'd0);
        send_word(9, 1'b0);
        chk("ovf_occ", 64'(occupancy), 64'd8);
        chk("ovf_flag", 64'(overflow), 64'd1);
        for (int k = 1; k <= 8; k++) begin
            chk("drain_valid", 64'(core_valid_out), 64'd1);
            chk("drain_data", core_data_out, exp_word(k));
            pop();
        end
        chk("drain_empty", 64'(core_valid_out), 64'd0);
        chk("drain_occ", 64'(occupancy), 64'd0);
        chk("ovf_sticky", 64'(overflow), 64'd1);

        // full with simultaneous dequeue
        do_reset();
        for (int k = 1; k <= 8; k++) send_word(k, 1'b0);
        send_word(9, 1'b1);
        chk("fd_occ", 64'(occupancy), 64'd8);
        chk("fd_ovf", 64'(overflow), 64'd0);
        for (int k = 2; k <= 9; k++) begin
            chk("fd_data", core_data_out, exp_word(k));
            pop();
        end
        chk("fd_empty", 64'(core_valid_out), 64'd0);
        chk("fd_tok", 64'(io_token_out), 64'd0);

        // token generation
        do_reset();
        for (int k = 1; k <= 5; k++) send_word(k, 1'b0);
        pop(); chk("tok1", 64'(io_token_out), 64'd0);
        pop(); chk("tok2", 64'(io_token_out), 64'd1);
        pop(); chk("tok3", 64'(io_token_out), 64'd1);
        pop(); chk("tok4", 64'(io_token_out), 64'd0);
        pop(); chk("tok5", 64'(io_token_out), 64'd0);

        // empty with last beat and ready: no dequeue that cycle
        do_reset();
        send_word(7, 1'b1);
        chk("er_occ", 64'(occupancy), 64'd1);
        chk("er_data", core_data_out, exp_word(7));

        // mid-word reset with inputs active during reset
        do_reset();
        beat(16'hDEAD, 1'b0);
        beat(16'hBEEF, 1'b0);
        rst         = 1'b1;
        io_valid_in = 1'b1;
        io_data_in  = 16'h5555;
        tick();
        rst         = 1'b0;
        io_valid_in = 1'b0;
        chk("mr_valid", 64'(core_valid_out), 64'd0);
        chk("mr_data", core_data_out, 64'd0);
        chk("mr_occ", 64'(occupancy), 64'd0);
        beat(16'h1111, 1'b0);
        beat(16'h2222, 1'b0);
        beat(16'h3333, 1'b0);
        beat(16'h4444, 1'b0);
        chk("mr_occ1", 64'(occupancy), 64'd1);
        chk("mr_word", core_data_out, 64'h44332211_44332211);
        pop();
        chk("mr_occ0", 64'(occupancy), 64'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
